// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl
// Steps the PWM timer's compare value through a small loadable table of duty
// values, one entry per timer period boundary (to_flag). The table is replayed
// repeat_cnt times (0 = forever), after which PWM is disabled and a one-cycle
// done pulse is produced. All outputs are registered.

module pwm_seq_ctrl #(
  parameter int DEPTH = 8,   // table entries, power of 2, >= 2
  parameter int AW    = 3,   // log2(DEPTH)
  parameter int DW    = 32   // compare value width
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] seq_len,
  input  logic [7:0]    repeat_cnt,
  input  logic          tbl_we,
  input  logic [AW-1:0] tbl_addr,
  input  logic [DW-1:0] tbl_wdata,
  input  logic          to_flag,
  output logic [DW-1:0] pwm_cmp,
  output logic          pwm_en,
  output logic          busy,
  output logic [AW-1:0] step,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and storage
  // ---------------------------------------------------------------------------
  state_t        r_state;
  state_t        w_state_nxt;

  logic [DW-1:0] r_table [DEPTH];

  logic [AW-1:0] r_len_q;     // last table index of the running sequence
  logic [7:0]    r_rep_q;     // number of passes of the running sequence
  logic [7:0]    r_pass;      // completed passes in the running sequence

  logic [DW-1:0] r_cmp;
  logic          r_en;
  logic          r_busy;
  logic [AW-1:0] r_step;
  logic          r_done;

  // Next-state values produced by the combinational FSM process
  logic [AW-1:0] w_len_nxt;
  logic [7:0]    w_rep_nxt;
  logic [7:0]    w_pass_nxt;
  logic [DW-1:0] w_cmp_nxt;
  logic          w_en_nxt;
  logic          w_busy_nxt;
  logic [AW-1:0] w_step_nxt;
  logic          w_done_nxt;

  // Table fetch path
  logic [AW-1:0] w_fetch_idx;
  logic [DW-1:0] w_fetch_data;

  // Sequence position helpers
  logic          w_last_entry;
  logic          w_more_passes;

  // ---------------------------------------------------------------------------
  // Table write port: any state, any cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      // NOTE: the table is cleared by reset on purpose; a restart after reset
      // must see all-zero duty values, so this array cannot be left uninitialised.
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else if (tbl_we) begin
      r_table[tbl_addr] <= tbl_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch index: the entry that pwm_cmp would load at this edge
  // ---------------------------------------------------------------------------
  always_comb begin
    w_fetch_idx = '0;
    if (r_state == S_RUN && r_step < r_len_q) begin
      w_fetch_idx = r_step + 1'b1;
    end
  end

  // A write to the entry being fetched in the same cycle is forwarded, so the
  // freshly written duty value takes effect immediately.
  assign w_fetch_data = (tbl_we && (tbl_addr == w_fetch_idx)) ? tbl_wdata
                                                              : r_table[w_fetch_idx];

  assign w_last_entry  = (r_step == r_len_q);
  // Pass arithmetic is done in 9 bits so pass+1 never wraps in the compare.
  assign w_more_passes = (r_rep_q == 8'd0) ||
                         (({1'b0, r_pass} + 9'd1) < {1'b0, r_rep_q});

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values, independent of block ordering.
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_len_nxt   = r_len_q;
    w_rep_nxt   = r_rep_q;
    w_pass_nxt  = r_pass;
    w_cmp_nxt   = r_cmp;
    w_en_nxt    = r_en;
    w_busy_nxt  = r_busy;
    w_step_nxt  = r_step;
    w_done_nxt  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // to_flag and stop are meaningless while idle
        if (start) begin
          w_state_nxt = S_RUN;
          w_len_nxt   = seq_len;
          w_rep_nxt   = repeat_cnt;
          w_pass_nxt  = 8'd0;
          w_step_nxt  = '0;
          w_cmp_nxt   = w_fetch_data;   // fetch index is 0 outside RUN
          w_en_nxt    = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end

      S_RUN: begin
        if (stop) begin
          // Abort takes priority over a coincident period boundary
          w_state_nxt = S_IDLE;
          w_pass_nxt  = 8'd0;
          w_step_nxt  = '0;
          w_cmp_nxt   = '0;
          w_en_nxt    = 1'b0;
          w_busy_nxt  = 1'b0;
        end else if (to_flag) begin
          if (!w_last_entry) begin
            w_step_nxt = r_step + 1'b1;
            w_cmp_nxt  = w_fetch_data;
          end else if (w_more_passes) begin
            // Wrap to entry 0; a forever sequence leaves the pass count alone
            w_step_nxt = '0;
            w_cmp_nxt  = w_fetch_data;  // fetch index is 0 on the last entry
            if (r_rep_q != 8'd0) begin
              w_pass_nxt = r_pass + 8'd1;
            end
          end else begin
            w_state_nxt = S_FINISH;
            w_pass_nxt  = 8'd0;
            w_step_nxt  = '0;
            w_cmp_nxt   = '0;
            w_en_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
      end

      S_FINISH: begin
        // Single completion cycle; start here is deliberately dropped
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_pass_nxt  = 8'd0;
        w_step_nxt  = '0;
        w_cmp_nxt   = '0;
        w_en_nxt    = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequence context and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_len_q <= '0;
      r_rep_q <= 8'd0;
      r_pass  <= 8'd0;
      r_cmp   <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_step  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_len_q <= w_len_nxt;
      r_rep_q <= w_rep_nxt;
      r_pass  <= w_pass_nxt;
      r_cmp   <= w_cmp_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
      r_step  <= w_step_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign pwm_cmp = r_cmp;
  assign pwm_en  = r_en;
  assign busy    = r_busy;
  assign step    = r_step;
  assign done    = r_done;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// tb_pwm_seq_ctrl
// Directed scenarios followed by randomized traffic, every cycle compared
// against a flag-count model of the sequencer: the running sequence is just
// "k flags consumed", step = k mod (len+1), finished when k = (len+1)*repeat.

module tb_pwm_seq_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 32;

  logic          HCLK;
  logic          HRESETn;
  logic          start;
  logic          stop;
  logic [AW-1:0] seq_len;
  logic [7:0]    repeat_cnt;
  logic          tbl_we;
  logic [AW-1:0] tbl_addr;
  logic [DW-1:0] tbl_wdata;
  logic          to_flag;
  logic [DW-1:0] pwm_cmp;
  logic          pwm_en;
  logic          busy;
  logic [AW-1:0] step;
  logic          done;

  int n_checks;
  int n_fail;

  // Reference model state
  logic [DW-1:0] m_tbl [DEPTH];
  bit            m_active;
  bit            m_finish;
  int            m_len;
  int            m_rep;
  int            m_k;
  logic [DW-1:0] m_cmp;

  pwm_seq_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .start      (start),
    .stop       (stop),
    .seq_len    (seq_len),
    .repeat_cnt (repeat_cnt),
    .tbl_we     (tbl_we),
    .tbl_addr   (tbl_addr),
    .tbl_wdata  (tbl_wdata),
    .to_flag    (to_flag),
    .pwm_cmp    (pwm_cmp),
    .pwm_en     (pwm_en),
    .busy       (busy),
    .step       (step),
    .done       (done)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = '0;
    m_active = 1'b0;
    m_finish = 1'b0;
    m_len    = 0;
    m_rep    = 0;
    m_k      = 0;
    m_cmp    = '0;
  endtask

  // Apply one clock edge worth of behaviour using the inputs held over it
  task automatic model_edge();
    logic [DW-1:0] nt [DEPTH];
    nt = m_tbl;
    if (tbl_we) nt[tbl_addr] = tbl_wdata;
    if (m_finish) begin
      m_finish = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_len    = int'(seq_len);
        m_rep    = int'(repeat_cnt);
        m_k      = 0;
        m_cmp    = nt[0];
      end
    end else if (stop) begin
      m_active = 1'b0;
    end else if (to_flag) begin
      m_k++;
      if (m_rep != 0 && m_k == (m_len + 1) * m_rep) begin
        m_active = 1'b0;
        m_finish = 1'b1;
      end else begin
        m_cmp = nt[m_k % (m_len + 1)];
      end
    end
    m_tbl = nt;
  endtask

  task automatic compare_outputs();
    int exp_step;
    exp_step = m_active ? (m_k % (m_len + 1)) : 0;
    check("pwm_cmp", pwm_cmp, m_active ? m_cmp : 32'd0);
    check("pwm_en",  32'(pwm_en), 32'(m_active));
    check("busy",    32'(busy),   32'(m_active));
    check("step",    32'(step),   32'(exp_step));
    check("done",    32'(done),   32'(m_finish));
  endtask

  // One clock with the currently driven inputs; pulses are cleared afterwards
  task automatic tick();
    @(posedge HCLK);
    model_edge();
    @(negedge HCLK);
    compare_outputs();
    start   = 1'b0;
    stop    = 1'b0;
    to_flag = 1'b0;
    tbl_we  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_write(input int addr, input logic [31:0] data);
    tbl_we    = 1'b1;
    tbl_addr  = AW'(addr);
    tbl_wdata = data;
  endtask

  task automatic write_tbl(input int addr, input logic [31:0] data);
    set_write(addr, data);
    tick();
  endtask

  initial begin
    logic [31:0] t1_exp [5];
    n_checks   = 0;
    n_fail     = 0;
    HRESETn    = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    seq_len    = '0;
    repeat_cnt = 8'd0;
    tbl_we     = 1'b0;
    tbl_addr   = '0;
    tbl_wdata  = '0;
    to_flag    = 1'b0;
    model_reset();

    #12;
    compare_outputs();
    #5 HRESETn = 1'b1;
    @(negedge HCLK);
    compare_outputs();

    // --- 1: three-entry ramp, two passes --------------------------------
    write_tbl(0, 32'd10);
    write_tbl(1, 32'd20);
    write_tbl(2, 32'd30);
    seq_len = 3'd2; repeat_cnt = 8'd2; start = 1'b1;
    tick();
    check("t1_first_cmp", pwm_cmp, 32'd10);
    t1_exp = '{32'd20, 32'd30, 32'd10, 32'd20, 32'd30};
    for (int f = 0; f < 6; f++) begin
      idle(4);
      to_flag = 1'b1;
      tick();
      if (f < 5) check("t1_cmp", pwm_cmp, t1_exp[f]);
    end
    check("t1_done", 32'(done), 32'd1);
    tick();
    check("t1_done_clr", 32'(done), 32'd0);
    check("t1_en_off", 32'(pwm_en), 32'd0);

    // --- 2: single entry, three passes, ignored restart --------------------
    write_tbl(0, 32'd7);
    seq_len = 3'd0; repeat_cnt = 8'd3; start = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      idle(1);
      if (f == 1) start = 1'b1;
      tick();
      to_flag = 1'b1;
      tick();
      if (f < 2) check("t2_cmp", pwm_cmp, 32'd7);
    end
    check("t2_done", 32'(done), 32'd1);
    idle(2);

    // --- 3: forever mode, stopped by stop ------------------------------
    write_tbl(0, 32'd100);
    write_tbl(1, 32'd200);
    seq_len = 3'd1; repeat_cnt = 8'd0; start = 1'b1;
    tick();
    for (int f = 1; f <= 20; f++) begin
      idle(1);
      to_flag = 1'b1;
      tick();
      check("t3_cmp", pwm_cmp, (f % 2 == 1) ? 32'd200 : 32'd100);
    end
    stop = 1'b1;
    tick();
    check("t3_stop_en", 32'(pwm_en), 32'd0);
    check("t3_stop_cmp", pwm_cmp, 32'd0);
    check("t3_stop_done", 32'(done), 32'd0);

    // --- 4: stop beats a coincident flag --------------------------------
    seq_len = 3'd3; repeat_cnt = 8'd1; start = 1'b1;
    tick();
    to_flag = 1'b1;
    tick();
    check("t4_step1", 32'(step), 32'd1);
    stop = 1'b1; to_flag = 1'b1;
    tick();
    check("t4_step", 32'(step), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    idle(1);

    // --- 5: write forwarding and late table update ----------------------
    seq_len = 3'd3; repeat_cnt = 8'd1; start = 1'b1;
    tick();
    to_flag = 1'b1; set_write(1, 32'd55);
    tick();
    check("t5_fwd", pwm_cmp, 32'd55);
    idle(1);
    write_tbl(2, 32'd66);
    idle(1);
    to_flag = 1'b1;
    tick();
    check("t5_late", pwm_cmp, 32'd66);
    stop = 1'b1;
    tick();

    // --- 6: asynchronous reset mid-sequence -----------------------------
    seq_len = 3'd3; repeat_cnt = 8'd0; start = 1'b1;
    tick();
    to_flag = 1'b1;
    tick();
    #2 HRESETn = 1'b0;
    #1;
    check("t6_rst_cmp",  pwm_cmp, 32'd0);
    check("t6_rst_en",   32'(pwm_en), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_step", 32'(step), 32'd0);
    model_reset();
    @(negedge HCLK);
    compare_outputs();
    #2 HRESETn = 1'b1;
    seq_len = 3'd1; repeat_cnt = 8'd1; start = 1'b1;
    tick();
    check("t6_restart_en",  32'(pwm_en), 32'd1);
    check("t6_restart_cmp", pwm_cmp, 32'd0);
    to_flag = 1'b1;
    tick();
    check("t6_zero_tbl", pwm_cmp, 32'd0);
    idle(2);

    // --- 7: randomized traffic -------------------------------------------
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(7) == 0) seq_len = AW'($urandom_range(DEPTH - 1));
      if ($urandom_range(7) == 0) repeat_cnt = 8'($urandom_range(3));
      start   = ($urandom_range(9) == 0);
      stop    = ($urandom_range(49) == 0);
      to_flag = ($urandom_range(3) == 0);
      if ($urandom_range(3) == 0) set_write($urandom_range(DEPTH - 1), $urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
